// File: rtl/atm_dos_ctrl_pkg.sv
// Shared types and constants for the global DOS flag controller.
package atm_dos_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALL   = 2'd1,
    ST_WAITPOS = 2'd2
  } dos_state_e;

  localparam logic [1:0] WIN0 = 2'd0;
  localparam logic [1:0] WIN1 = 2'd1;
  localparam logic [1:0] WIN2 = 2'd2;
  localparam logic [1:0] WIN3 = 2'd3;

  localparam int unsigned STALL_CYC_MIN = 1;
  localparam int unsigned STALL_CYC_MAX = 15;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/atm_dos_ctrl.sv
// Global DOS flag: one decision per M1 fetch from the addressed window's pager,
// with a Z80 clock stall on DOS entry that releases on a Z80 rising edge.
module atm_dos_ctrl
  import atm_dos_ctrl_pkg::*;
#(
  parameter int unsigned STALL_CYC = 4,
  parameter logic        RST_DOS   = 1'b0
) (
  input  logic       fclk,
  input  logic       arst_n,
  input  logic       zpos,
  input  logic       zneg,
  input  logic [1:0] za,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic [3:0] dos_on_req,
  input  logic [3:0] dos_off_req,
  input  logic       dos_force_off,
  output logic       dos,
  output logic       zclk_stall,
  output logic       dos_chg
);

  // Out-of-range lengths are clamped to the legal window.
  localparam int unsigned STALL_CLAMP =
    (STALL_CYC < STALL_CYC_MIN) ? STALL_CYC_MIN :
    (STALL_CYC > STALL_CYC_MAX) ? STALL_CYC_MAX : STALL_CYC;
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CLAMP - 1);

  dos_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fetch_done, fetch_done_nxt;
  logic             dos_nxt;
  logic             fetch_ev_c;
  logic             on_sel_c, off_sel_c;

  assign fetch_ev_c = zneg && !m1_n && !mreq_n && !fetch_done;
  assign on_sel_c   = dos_on_req[za];
  assign off_sel_c  = dos_off_req[za];

  // State and output registers.
  always_ff @(posedge fclk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      fetch_done <= 1'b0;
      dos        <= RST_DOS;
      dos_chg    <= 1'b0;
      zclk_stall <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      fetch_done <= fetch_done_nxt;
      dos        <= dos_nxt;
      dos_chg    <= dos_nxt ^ dos;
      zclk_stall <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, stall counter and DOS decision.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    dos_nxt        = dos;
    fetch_done_nxt = fetch_done;

    if (fetch_ev_c)
      fetch_done_nxt = 1'b1;
    else if (m1_n)
      fetch_done_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (fetch_ev_c) begin
          if (on_sel_c && !dos) begin
            dos_nxt   = 1'b1;
            cnt_nxt   = STALL_LOAD;
            state_nxt = ST_STALL;
          end else if (off_sel_c && !on_sel_c && dos) begin
            dos_nxt = 1'b0;
          end
        end
      end
      ST_STALL: begin
        if (cnt == '0)
          state_nxt = ST_WAITPOS;
        else
          cnt_nxt = cnt - CNT_W'(1);
      end
      ST_WAITPOS: begin
        if (zpos)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Port-side clear overrides any pager decision but leaves a stall running.
    if (dos_force_off)
      dos_nxt = 1'b0;
  end

endmodule

// File: tb/tb_atm_dos_ctrl.sv
// Directed bench for atm_dos_ctrl: default instance plus a STALL_CYC=8 instance
// used for the asynchronous-reset and forced-clear cases.
module tb_atm_dos_ctrl;
  import atm_dos_ctrl_pkg::*;

  logic       fclk = 1'b0;
  logic       arst_n, arst8_n;
  logic       zpos, zneg, m1_n, mreq_n, dos_force_off;
  logic [1:0] za;
  logic [3:0] dos_on_req, dos_off_req;
  logic       dos, zclk_stall, dos_chg;
  logic       dos8, zclk_stall8, dos_chg8;

  int n_tests = 0;
  int n_fail  = 0;
  int chg_cnt = 0;
  int rise_cnt = 0;
  int c0, s0;
  logic stall_q = 1'b0;

  atm_dos_ctrl dut (
    .fclk(fclk), .arst_n(arst_n), .zpos(zpos), .zneg(zneg), .za(za),
    .m1_n(m1_n), .mreq_n(mreq_n), .dos_on_req(dos_on_req),
    .dos_off_req(dos_off_req), .dos_force_off(dos_force_off),
    .dos(dos), .zclk_stall(zclk_stall), .dos_chg(dos_chg)
  );

  atm_dos_ctrl #(.STALL_CYC(8), .RST_DOS(1'b0)) dut8 (
    .fclk(fclk), .arst_n(arst_n && arst8_n), .zpos(zpos), .zneg(zneg), .za(za),
    .m1_n(m1_n), .mreq_n(mreq_n), .dos_on_req(dos_on_req),
    .dos_off_req(dos_off_req), .dos_force_off(dos_force_off),
    .dos(dos8), .zclk_stall(zclk_stall8), .dos_chg(dos_chg8)
  );

  always #5 fclk = ~fclk;

  always @(negedge fclk) begin
    if (dos_chg) chg_cnt <= chg_cnt + 1;
    if (zclk_stall && !stall_q) rise_cnt <= rise_cnt + 1;
    stall_q <= zclk_stall;
  end

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zneg_tick();
    zneg = 1'b1;
    tick();
    zneg = 1'b0;
  endtask

  task automatic zpos_tick();
    zpos = 1'b1;
    tick();
    zpos = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0; arst8_n = 1'b1;
    zpos = 1'b0; zneg = 1'b0; m1_n = 1'b1; mreq_n = 1'b1; dos_force_off = 1'b0;
    za = WIN0; dos_on_req = 4'b0; dos_off_req = 4'b0;
    repeat (2) tick();
    chk("rst_dos", 8'(dos), 8'h0);
    chk("rst_stall", 8'(zclk_stall), 8'h0);
    chk("rst_chg", 8'(dos_chg), 8'h0);
    arst_n = 1'b1;
    tick();

    // Window 0 turn-on with stall
    za = WIN0; dos_on_req = 4'b0001; m1_n = 1'b0; mreq_n = 1'b0;
    tick();
    chk("t1_no_zneg_dos", 8'(dos), 8'h0);
    zneg_tick();
    chk("t1_dos", 8'(dos), 8'h1);
    chk("t1_chg", 8'(dos_chg), 8'h1);
    chk("t1_stall_rise", 8'(zclk_stall), 8'h1);
    m1_n = 1'b1; mreq_n = 1'b1; dos_on_req = 4'b0;
    tick();
    chk("t1_chg_single", 8'(dos_chg), 8'h0);
    chk("t1_stall_e1", 8'(zclk_stall), 8'h1);
    zpos_tick();
    chk("t1_early_zpos", 8'(zclk_stall), 8'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_stall_hold", 8'(zclk_stall), 8'h1);
    end
    zpos_tick();
    chk("t1_stall_release", 8'(zclk_stall), 8'h0);
    chk("t1_dos_kept", 8'(dos), 8'h1);

    // Window 3 turn-off, no stall
    za = WIN3; dos_off_req = 4'b1000; m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t2_dos", 8'(dos), 8'h0);
    chk("t2_chg", 8'(dos_chg), 8'h1);
    chk("t2_stall", 8'(zclk_stall), 8'h0);
    m1_n = 1'b1; mreq_n = 1'b1; dos_off_req = 4'b0;
    tick();
    chk("t2_chg_single", 8'(dos_chg), 8'h0);
    chk("t2_stall_after", 8'(zclk_stall), 8'h0);

    // Request on a different window is ignored
    za = WIN1; dos_on_req = 4'b0100; m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t3_dos", 8'(dos), 8'h0);
    chk("t3_chg", 8'(dos_chg), 8'h0);
    chk("t3_stall", 8'(zclk_stall), 8'h0);
    m1_n = 1'b1; mreq_n = 1'b1; dos_on_req = 4'b0;
    tick();

    // On and off together: on wins
    za = WIN1; dos_on_req = 4'b0010; dos_off_req = 4'b0010; m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t4_dos", 8'(dos), 8'h1);
    chk("t4_chg", 8'(dos_chg), 8'h1);
    chk("t4_stall", 8'(zclk_stall), 8'h1);
    m1_n = 1'b1; mreq_n = 1'b1; dos_on_req = 4'b0; dos_off_req = 4'b0;
    repeat (4) tick();
    chk("t4_stall_waitpos", 8'(zclk_stall), 8'h1);
    zpos_tick();
    chk("t4_stall_release", 8'(zclk_stall), 8'h0);

    // Forced clear in IDLE
    dos_force_off = 1'b1;
    tick();
    dos_force_off = 1'b0;
    chk("t5_force_dos", 8'(dos), 8'h0);
    chk("t5_force_chg", 8'(dos_chg), 8'h1);
    tick();
    chk("t5_force_chg_single", 8'(dos_chg), 8'h0);

    // M1 held low across three zneg strobes: one decision only
    c0 = chg_cnt; s0 = rise_cnt;
    za = WIN0; dos_on_req = 4'b0001; m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t5_dos_on", 8'(dos), 8'h1);
    dos_on_req = 4'b0; dos_off_req = 4'b0001;
    repeat (4) tick();
    zpos_tick();
    chk("t5_stall_done", 8'(zclk_stall), 8'h0);
    zneg_tick();
    chk("t5_zneg2_dos", 8'(dos), 8'h1);
    tick();
    zneg_tick();
    chk("t5_zneg3_dos", 8'(dos), 8'h1);
    tick();
    chk("t5_chg_count", 8'(chg_cnt - c0), 8'h1);
    chk("t5_stall_count", 8'(rise_cnt - s0), 8'h1);
    m1_n = 1'b1; mreq_n = 1'b1;
    tick();
    m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t5_next_m1_dos", 8'(dos), 8'h0);
    m1_n = 1'b1; mreq_n = 1'b1; dos_off_req = 4'b0;
    tick();

    // STALL_CYC=8 instance: asynchronous reset mid-stall
    arst8_n = 1'b0;
    tick();
    arst8_n = 1'b1;
    tick();
    chk("t6_rst_dos8", 8'(dos8), 8'h0);
    za = WIN0; dos_on_req = 4'b0001; m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t6_dos8_on", 8'(dos8), 8'h1);
    chk("t6_stall8_on", 8'(zclk_stall8), 8'h1);
    m1_n = 1'b1; mreq_n = 1'b1; dos_on_req = 4'b0;
    repeat (3) tick();
    chk("t6_stall8_mid", 8'(zclk_stall8), 8'h1);
    arst8_n = 1'b0;
    #1;
    chk("t6_async_stall8", 8'(zclk_stall8), 8'h0);
    chk("t6_async_dos8", 8'(dos8), 8'h0);
    tick();
    arst8_n = 1'b1;
    tick();
    chk("t6_post_rst_stall8", 8'(zclk_stall8), 8'h0);
    zpos_tick();
    chk("t6_post_rst_idle8", 8'(zclk_stall8), 8'h0);

    // Forced clear during stall: stall completes on zpos
    za = WIN0; dos_on_req = 4'b0001; m1_n = 1'b0; mreq_n = 1'b0;
    zneg_tick();
    chk("t7_dos8_on", 8'(dos8), 8'h1);
    chk("t7_stall8_on", 8'(zclk_stall8), 8'h1);
    m1_n = 1'b1; mreq_n = 1'b1; dos_on_req = 4'b0;
    tick();
    dos_force_off = 1'b1;
    tick();
    dos_force_off = 1'b0;
    chk("t7_force_dos8", 8'(dos8), 8'h0);
    chk("t7_force_chg8", 8'(dos_chg8), 8'h1);
    chk("t7_force_stall8", 8'(zclk_stall8), 8'h1);
    tick();
    chk("t7_chg8_single", 8'(dos_chg8), 8'h0);
    repeat (5) tick();
    chk("t7_stall8_waitpos", 8'(zclk_stall8), 8'h1);
    zpos_tick();
    chk("t7_stall8_release", 8'(zclk_stall8), 8'h0);
    chk("t7_dos8_final", 8'(dos8), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
